morph_window_minmax: RTL

- Streaming 3x3 grey-scale dilation/erosion generator.
- Accepts a raster pixel stream and emits each pixel together with its 3x3 max (dilate) and 3x3 min (erode).
- Output is centre-aligned and ready to drive the pixel/dilate/erode inputs of the edge-enhancement stage.
- Two internal line buffers; valid/ready handshake on both sides; end-of-frame flush.

---
 rtl/morph_window_minmax.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/morph_window_minmax.sv
// Streaming 3x3 grey-scale dilation/erosion with centre-aligned pixel, max and min outputs.
// Define MORPH_BORDER_CLIP_EN to use only in-image taps at borders; otherwise border pixels pass through.
module morph_window_minmax #(
    parameter int IMG_W = 64,
    parameter int IMG_H = 64,
    parameter int DW    = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_pixel,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_pixel,
    output logic [DW-1:0] out_dilate,
    output logic [DW-1:0] out_erode,
    output logic          out_last,
    output logic          busy
);

    // state | meaning
    // RUN   | accepting frame pixels, window shifts on each accepted pixel
    // FLUSH | frame fully accepted, shifting IMG_W+1 zero pixels to drain the last outputs
    typedef enum logic {RUN, FLUSH} state_t;

    localparam int NPIX = IMG_W * IMG_H;
    localparam int IW   = $clog2(NPIX);
    localparam int PW   = $clog2(IMG_W + 2);
    localparam int RW   = $clog2(IMG_H);
    localparam int CW   = $clog2(IMG_W);
    localparam int SL   = 2 * IMG_W + 2;

    state_t          state, state_nx;
    logic [DW-1:0]   sr [0:SL-1];
    logic [DW-1:0]   nwin [0:SL];
    logic [IW-1:0]   in_idx;
    logic [PW-1:0]   fill_cnt;
    logic [PW-1:0]   flush_cnt;
    logic [RW-1:0]   pos_row;
    logic [CW-1:0]   pos_col;
    logic            adv, shift, produce, pos_last;
    logic            row_top, row_bot, col_lft, col_rgt, is_border;
    logic [DW-1:0]   pix_in, centre, win_max, win_min, dil_nx, ero_nx;
    logic [DW-1:0]   tap_hi [0:8];
    logic [DW-1:0]   tap_lo [0:8];

    assign adv = !out_valid || out_ready;

    always_comb begin
        state_nx = state;
        in_ready = 1'b0;
        shift    = 1'b0;
        case (state)
            RUN: begin
                in_ready = adv && !rst;
                shift    = in_valid && in_ready;
                if (shift && in_idx == IW'(NPIX - 1))
                    state_nx = FLUSH;
            end
            FLUSH: begin
                shift = adv;
                if (adv && flush_cnt == PW'(IMG_W))
                    state_nx = RUN;
            end
            default: state_nx = RUN;
        endcase
    end

    // fill_cnt saturates at IMG_W+1: from then on each shift completes one centre position
    assign produce  = shift && (fill_cnt == PW'(IMG_W + 1));
    assign row_top  = (pos_row == '0);
    assign row_bot  = (pos_row == RW'(IMG_H - 1));
    assign col_lft  = (pos_col == '0);
    assign col_rgt  = (pos_col == CW'(IMG_W - 1));
    assign is_border = row_top || row_bot || col_lft || col_rgt;
    assign pos_last = row_bot && col_rgt;
    assign pix_in   = (state == RUN) ? in_pixel : '0;

    always_comb begin
        nwin[0] = pix_in;
        for (int i = 1; i <= SL; i++)
            nwin[i] = sr[i-1];
    end

    // Tap k: k/3 = 0 is the row below the centre (newest), k%3 = 0 is the right-hand column
    for (genvar k = 0; k < 9; k++) begin : g_tap
        localparam bit ABOVE = (k / 3 == 2);
        localparam bit BELOW = (k / 3 == 0);
        localparam bit LEFT  = (k % 3 == 2);
        localparam bit RIGHT = (k % 3 == 0);
        logic [DW-1:0] tap;
        assign tap = nwin[(k / 3) * IMG_W + (k % 3)];
`ifdef MORPH_BORDER_CLIP_EN
        logic tap_ok;
        assign tap_ok = !((ABOVE && row_top) || (BELOW && row_bot) ||
                          (LEFT && col_lft) || (RIGHT && col_rgt));
        assign tap_hi[k] = tap_ok ? tap : '0;
        assign tap_lo[k] = tap_ok ? tap : '1;
`else
        assign tap_hi[k] = tap;
        assign tap_lo[k] = tap;
`endif
    end

    assign centre = nwin[IMG_W + 1];

    always_comb begin
        win_max = '0;
        win_min = '1;
        for (int k = 0; k < 9; k++) begin
            if (tap_hi[k] > win_max) win_max = tap_hi[k];
            if (tap_lo[k] < win_min) win_min = tap_lo[k];
        end
    end

`ifdef MORPH_BORDER_CLIP_EN
    assign dil_nx = win_max;
    assign ero_nx = win_min;
`else
    assign dil_nx = is_border ? centre : win_max;
    assign ero_nx = is_border ? centre : win_min;
`endif

    // Line storage carries no reset; stale contents only ever reach masked or bypassed taps
    always_ff @(posedge clk) begin
        if (shift) begin
            sr[0] <= pix_in;
            for (int i = 1; i < SL; i++)
                sr[i] <= sr[i-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= RUN;
            in_idx     <= '0;
            fill_cnt   <= '0;
            flush_cnt  <= '0;
            pos_row    <= '0;
            pos_col    <= '0;
            out_valid  <= 1'b0;
            out_pixel  <= '0;
            out_dilate <= '0;
            out_erode  <= '0;
            out_last   <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == RUN && shift)
                in_idx <= (in_idx == IW'(NPIX - 1)) ? '0 : in_idx + 1'b1;
            if (state == FLUSH && shift)
                flush_cnt <= (flush_cnt == PW'(IMG_W)) ? '0 : flush_cnt + 1'b1;
            if (shift) begin
                if (!produce)
                    fill_cnt <= fill_cnt + 1'b1;
                else if (pos_last)
                    fill_cnt <= '0;
            end
            if (produce) begin
                if (col_rgt) begin
                    pos_col <= '0;
                    pos_row <= pos_last ? '0 : pos_row + 1'b1;
                end else begin
                    pos_col <= pos_col + 1'b1;
                end
            end
            if (adv) begin
                out_valid <= produce;
                out_last  <= produce && pos_last;
                if (produce) begin
                    out_pixel  <= centre;
                    out_dilate <= dil_nx;
                    out_erode  <= ero_nx;
                end
            end
            if (out_valid && out_ready && out_last)
                busy <= 1'b0;
            if (state == RUN && shift)
                busy <= 1'b1;
        end
    end

endmodule
